// File: rtl/axi_id_remapper.sv
// AXI4 ID-width compressor: maps wide upstream IDs onto a small pool of downstream IDs, restores them on R/B.
// Latency: zero cycles on every channel (address, data and response paths are combinational).
// Backpressure: AW/AR stall (valid and ready both low) while the ID has no slot or its slot is at max depth.

module axi_id_map_table #(
   parameter int S_ID_WIDTH     = 8,
   parameter int M_ID_WIDTH     = 2,
   parameter int MAX_TXN_PER_ID = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [S_ID_WIDTH-1:0] req_id,
   input  logic                  req_fire,
   output logic                  accept,
   output logic [M_ID_WIDTH-1:0] req_m_id,
   input  logic [M_ID_WIDTH-1:0] rsp_id,
   input  logic                  rsp_fire,
   input  logic                  rsp_done,
   output logic [S_ID_WIDTH-1:0] rsp_s_id,
   output logic                  rsp_err
);
   localparam int N  = 1 << M_ID_WIDTH;
   localparam int CW = $clog2(MAX_TXN_PER_ID + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TXN_PER_ID);

   typedef struct packed {
      logic                  vld;
      logic [S_ID_WIDTH-1:0] s_id;
      logic [CW-1:0]         cnt;
   } entry_t;

   entry_t tbl [N];

   logic                  hit_any;
   logic                  free_any;
   logic [M_ID_WIDTH-1:0] hit_idx;
   logic [M_ID_WIDTH-1:0] free_idx;
   logic [N-1:0]          inc_vec;
   logic [N-1:0]          dec_vec;

   // Descending scan so the lowest free index is the one left standing.
   always_comb begin
      hit_any  = 1'b0;
      free_any = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (tbl[i].vld && (tbl[i].s_id == req_id)) begin
            hit_any = 1'b1;
            hit_idx = M_ID_WIDTH'(i);
         end
         if (!tbl[i].vld) begin
            free_any = 1'b1;
            free_idx = M_ID_WIDTH'(i);
         end
      end
   end

   assign accept   = hit_any ? (tbl[hit_idx].cnt < MAX_CNT) : free_any;
   assign req_m_id = hit_any ? hit_idx : free_idx;
   assign rsp_s_id = tbl[rsp_id].vld ? tbl[rsp_id].s_id : '0;
   assign rsp_err  = rsp_fire && !tbl[rsp_id].vld;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 0; i < N; i++) begin
         inc_vec[i] = req_fire && (req_m_id == M_ID_WIDTH'(i));
         dec_vec[i] = rsp_done && (rsp_id == M_ID_WIDTH'(i)) && tbl[i].vld;
      end
   end

   // A request and a completion on the same entry in one cycle cancel out.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N; i++) begin
            tbl[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               if (tbl[i].vld) begin
                  tbl[i].cnt <= tbl[i].cnt + CW'(1);
               end else begin
                  tbl[i] <= '{vld: 1'b1, s_id: req_id, cnt: CW'(1)};
               end
            end else if (dec_vec[i] && !inc_vec[i]) begin
               tbl[i].cnt <= tbl[i].cnt - CW'(1);
               if (tbl[i].cnt == CW'(1)) begin
                  tbl[i].vld <= 1'b0;
               end
            end
         end
      end
   end
endmodule

module axi_id_remapper #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int S_ID_WIDTH     = 8,
   parameter int M_ID_WIDTH     = 2,
   parameter int MAX_TXN_PER_ID = 8
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   // upstream write address
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [S_ID_WIDTH-1:0]   s_axi_awid,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awlock,
   input  logic [3:0]              s_axi_awcache,
   input  logic [2:0]              s_axi_awprot,
   input  logic [3:0]              s_axi_awqos,
   input  logic [3:0]              s_axi_awregion,
   // upstream read address
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [S_ID_WIDTH-1:0]   s_axi_arid,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arlock,
   input  logic [3:0]              s_axi_arcache,
   input  logic [2:0]              s_axi_arprot,
   input  logic [3:0]              s_axi_arqos,
   input  logic [3:0]              s_axi_arregion,
   // upstream write data
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   // upstream write response
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   output logic [1:0]              s_axi_bresp,
   output logic [S_ID_WIDTH-1:0]   s_axi_bid,
   // upstream read data
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic [S_ID_WIDTH-1:0]   s_axi_rid,
   output logic                    s_axi_rlast,
   // downstream write address
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [M_ID_WIDTH-1:0]   m_axi_awid,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awlock,
   output logic [3:0]              m_axi_awcache,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic [3:0]              m_axi_awregion,
   // downstream read address
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [M_ID_WIDTH-1:0]   m_axi_arid,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arlock,
   output logic [3:0]              m_axi_arcache,
   output logic [2:0]              m_axi_arprot,
   output logic [3:0]              m_axi_arqos,
   output logic [3:0]              m_axi_arregion,
   // downstream write data
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   // downstream write response
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   input  logic [M_ID_WIDTH-1:0]   m_axi_bid,
   // downstream read data
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic [M_ID_WIDTH-1:0]   m_axi_rid,
   input  logic                    m_axi_rlast,
   output logic                    id_err
);
   logic                  rd_accept;
   logic                  rd_err;
   logic                  wr_accept;
   logic                  wr_err;
   logic [M_ID_WIDTH-1:0] rd_m_id;
   logic [M_ID_WIDTH-1:0] wr_m_id;
   logic [S_ID_WIDTH-1:0] rd_s_id;
   logic [S_ID_WIDTH-1:0] wr_s_id;
   logic                  rd_rsp_fire;
   logic                  wr_rsp_fire;

   assign rd_rsp_fire = m_axi_rvalid && s_axi_rready;
   assign wr_rsp_fire = m_axi_bvalid && s_axi_bready;

   axi_id_map_table #(
      .S_ID_WIDTH    (S_ID_WIDTH),
      .M_ID_WIDTH    (M_ID_WIDTH),
      .MAX_TXN_PER_ID(MAX_TXN_PER_ID)
   ) u_rd_table (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req_id  (s_axi_arid),
      .req_fire(s_axi_arvalid && m_axi_arready && rd_accept),
      .accept  (rd_accept),
      .req_m_id(rd_m_id),
      .rsp_id  (m_axi_rid),
      .rsp_fire(rd_rsp_fire),
      .rsp_done(rd_rsp_fire && m_axi_rlast),
      .rsp_s_id(rd_s_id),
      .rsp_err (rd_err)
   );

   axi_id_map_table #(
      .S_ID_WIDTH    (S_ID_WIDTH),
      .M_ID_WIDTH    (M_ID_WIDTH),
      .MAX_TXN_PER_ID(MAX_TXN_PER_ID)
   ) u_wr_table (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req_id  (s_axi_awid),
      .req_fire(s_axi_awvalid && m_axi_awready && wr_accept),
      .accept  (wr_accept),
      .req_m_id(wr_m_id),
      .rsp_id  (m_axi_bid),
      .rsp_fire(wr_rsp_fire),
      .rsp_done(wr_rsp_fire),
      .rsp_s_id(wr_s_id),
      .rsp_err (wr_err)
   );

   assign m_axi_awvalid  = s_axi_awvalid && wr_accept;
   assign s_axi_awready  = m_axi_awready && wr_accept;
   assign m_axi_awid     = wr_m_id;
   assign m_axi_awaddr   = s_axi_awaddr;
   assign m_axi_awlen    = s_axi_awlen;
   assign m_axi_awsize   = s_axi_awsize;
   assign m_axi_awburst  = s_axi_awburst;
   assign m_axi_awlock   = s_axi_awlock;
   assign m_axi_awcache  = s_axi_awcache;
   assign m_axi_awprot   = s_axi_awprot;
   assign m_axi_awqos    = s_axi_awqos;
   assign m_axi_awregion = s_axi_awregion;

   assign m_axi_arvalid  = s_axi_arvalid && rd_accept;
   assign s_axi_arready  = m_axi_arready && rd_accept;
   assign m_axi_arid     = rd_m_id;
   assign m_axi_araddr   = s_axi_araddr;
   assign m_axi_arlen    = s_axi_arlen;
   assign m_axi_arsize   = s_axi_arsize;
   assign m_axi_arburst  = s_axi_arburst;
   assign m_axi_arlock   = s_axi_arlock;
   assign m_axi_arcache  = s_axi_arcache;
   assign m_axi_arprot   = s_axi_arprot;
   assign m_axi_arqos    = s_axi_arqos;
   assign m_axi_arregion = s_axi_arregion;

   assign m_axi_wvalid   = s_axi_wvalid;
   assign s_axi_wready   = m_axi_wready;
   assign m_axi_wdata    = s_axi_wdata;
   assign m_axi_wstrb    = s_axi_wstrb;
   assign m_axi_wlast    = s_axi_wlast;

   assign s_axi_bvalid   = m_axi_bvalid;
   assign m_axi_bready   = s_axi_bready;
   assign s_axi_bresp    = m_axi_bresp;
   assign s_axi_bid      = wr_s_id;

   assign s_axi_rvalid   = m_axi_rvalid;
   assign m_axi_rready   = s_axi_rready;
   assign s_axi_rdata    = m_axi_rdata;
   assign s_axi_rresp    = m_axi_rresp;
   assign s_axi_rlast    = m_axi_rlast;
   assign s_axi_rid      = rd_s_id;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         id_err <= 1'b0;
      end else if (rd_err || wr_err) begin
         id_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_id_remapper.sv
// Bench for axi_id_remapper: directed vector table, reset corner sequence, then random traffic
// checked against a per-upstream-ID outstanding-count model.
module tb_axi_id_remapper;
   localparam int AW = 32, DW = 64, SW = 8, MW = 2, MAXT = 8, NM = 4;

   logic aclk = 1'b0;
   logic aresetn;
   always #5 aclk = ~aclk;

   logic s_axi_awvalid, s_axi_awready, s_axi_awlock;
   logic [AW-1:0] s_axi_awaddr;
   logic [SW-1:0] s_axi_awid;
   logic [7:0] s_axi_awlen;
   logic [2:0] s_axi_awsize, s_axi_awprot;
   logic [1:0] s_axi_awburst;
   logic [3:0] s_axi_awcache, s_axi_awqos, s_axi_awregion;
   logic s_axi_arvalid, s_axi_arready, s_axi_arlock;
   logic [AW-1:0] s_axi_araddr;
   logic [SW-1:0] s_axi_arid;
   logic [7:0] s_axi_arlen;
   logic [2:0] s_axi_arsize, s_axi_arprot;
   logic [1:0] s_axi_arburst;
   logic [3:0] s_axi_arcache, s_axi_arqos, s_axi_arregion;
   logic s_axi_wvalid, s_axi_wready, s_axi_wlast;
   logic [DW-1:0] s_axi_wdata;
   logic [DW/8-1:0] s_axi_wstrb;
   logic s_axi_bvalid, s_axi_bready;
   logic [1:0] s_axi_bresp;
   logic [SW-1:0] s_axi_bid;
   logic s_axi_rvalid, s_axi_rready, s_axi_rlast;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0] s_axi_rresp;
   logic [SW-1:0] s_axi_rid;

   logic m_axi_awvalid, m_axi_awready, m_axi_awlock;
   logic [AW-1:0] m_axi_awaddr;
   logic [MW-1:0] m_axi_awid;
   logic [7:0] m_axi_awlen;
   logic [2:0] m_axi_awsize, m_axi_awprot;
   logic [1:0] m_axi_awburst;
   logic [3:0] m_axi_awcache, m_axi_awqos, m_axi_awregion;
   logic m_axi_arvalid, m_axi_arready, m_axi_arlock;
   logic [AW-1:0] m_axi_araddr;
   logic [MW-1:0] m_axi_arid;
   logic [7:0] m_axi_arlen;
   logic [2:0] m_axi_arsize, m_axi_arprot;
   logic [1:0] m_axi_arburst;
   logic [3:0] m_axi_arcache, m_axi_arqos, m_axi_arregion;
   logic m_axi_wvalid, m_axi_wready, m_axi_wlast;
   logic [DW-1:0] m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic m_axi_bvalid, m_axi_bready;
   logic [1:0] m_axi_bresp;
   logic [MW-1:0] m_axi_bid;
   logic m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic [DW-1:0] m_axi_rdata;
   logic [1:0] m_axi_rresp;
   logic [MW-1:0] m_axi_rid;
   logic id_err;

   axi_id_remapper dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
      .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
      .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos), .s_axi_awregion(s_axi_awregion),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
      .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
      .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
      .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
      .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp), .m_axi_bid(m_axi_bid),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
      .id_err(id_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
      s_axi_awburst = 2'd1; s_axi_awlock = 0; s_axi_awcache = '0; s_axi_awprot = '0;
      s_axi_awqos = '0; s_axi_awregion = '0;
      s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
      s_axi_arburst = 2'd1; s_axi_arlock = 0; s_axi_arcache = '0; s_axi_arprot = '0;
      s_axi_arqos = '0; s_axi_arregion = '0;
      s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
      s_axi_bready = 1; s_axi_rready = 1;
      m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
      m_axi_bvalid = 0; m_axi_bresp = '0; m_axi_bid = '0;
      m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rid = '0; m_axi_rlast = 0;
   endtask

   // Reference model: outstanding count and assigned downstream ID, indexed by upstream ID.
   int   ocnt [2][256];
   int   omap [2][256];
   logic merr;

   task automatic model_clear();
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 256; s++) begin
            ocnt[d][s] = 0;
            omap[d][s] = 0;
         end
      merr = 0;
   endtask

   function automatic int owner(input int d, input int m);
      int o = -1;
      for (int s = 0; s < 256; s++)
         if (ocnt[d][s] > 0 && omap[d][s] == m) o = s;
      return o;
   endfunction

   task automatic predict(input int d, input int sid, output logic ok, output int mid);
      ok = 0;
      mid = 0;
      if (ocnt[d][sid] > 0) begin
         ok = (ocnt[d][sid] < MAXT);
         mid = omap[d][sid];
      end else begin
         for (int m = NM - 1; m >= 0; m--)
            if (owner(d, m) < 0) begin
               ok = 1;
               mid = m;
            end
      end
   endtask

   task automatic model_step(input int d, input logic req, input int sid, input int mid,
                             input logic rsp, input logic done, input int rm);
      int ow;
      ow = owner(d, rm);
      if (rsp) begin
         if (ow < 0) merr = 1;
         else if (done) ocnt[d][ow]--;
      end
      if (req) begin
         if (ocnt[d][sid] == 0) omap[d][sid] = mid;
         ocnt[d][sid]++;
      end
   endtask

   function automatic logic [MW-1:0] pick_rsp(input int d);
      int c[$];
      for (int m = 0; m < NM; m++)
         if (owner(d, m) >= 0) c.push_back(m);
      if (c.size() == 0 || $urandom_range(0, 9) == 0) return MW'($urandom_range(0, NM - 1));
      return MW'(c[$urandom_range(0, c.size() - 1)]);
   endfunction

   typedef struct {
      logic          arv;
      logic [SW-1:0] arid;
      logic          rv;
      logic [MW-1:0] rid;
      logic          rlast;
      logic          awv;
      logic [SW-1:0] awid;
      logic          bv;
      logic [MW-1:0] bid;
      logic          e_ar;
      logic [MW-1:0] e_arid;
      logic [SW-1:0] e_rid;
      logic          e_aw;
      logic [MW-1:0] e_awid;
      logic [SW-1:0] e_bid;
      logic          e_err;
   } vec_t;

   function automatic vec_t rd(logic arv, logic [SW-1:0] arid, logic rv, logic [MW-1:0] rid,
                               logic rlast, logic e_ok, logic [MW-1:0] e_arid, logic [SW-1:0] e_rid);
      return '{arv, arid, rv, rid, rlast, 1'b0, 8'h00, 1'b0, 2'd0,
               e_ok, e_arid, e_rid, 1'b0, 2'd0, 8'h00, 1'b0};
   endfunction

   function automatic vec_t wr(logic awv, logic [SW-1:0] awid, logic bv, logic [MW-1:0] bid,
                               logic e_ok, logic [MW-1:0] e_awid, logic [SW-1:0] e_bid, logic e_err);
      return '{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, awv, awid, bv, bid,
               1'b0, 2'd0, 8'h00, e_ok, e_awid, e_bid, e_err};
   endfunction

   vec_t vecs[$];

   task automatic do_reset();
      drive_idle();
      aresetn = 0;
      m_axi_arready = 1;
      model_clear();
      repeat (2) @(negedge aclk);
      #4;
      chk("rst id_err", 64'(id_err), 64'(0));
      chk("rst m_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("rst s_arready", 64'(s_axi_arready), 64'(1));
      chk("rst m_arid", 64'(m_axi_arid), 64'(0));
      chk("rst s_rvalid", 64'(s_axi_rvalid), 64'(0));
      @(negedge aclk);
      aresetn = 1;
      m_axi_arready = 0;
   endtask

   logic ok_r, ok_w, rsp_r, rsp_w;
   int   mid_r, mid_w, ow_r, ow_w;

   initial begin
      // Directed table: read-side mapping, full table, max depth, then write-side corners.
      vecs.push_back(rd(1, 8'h5A, 0, 0, 0, 1, 0, 8'h00));
      vecs.push_back(rd(0, 8'h00, 1, 0, 1, 0, 0, 8'h5A));
      vecs.push_back(rd(1, 8'h10, 0, 0, 0, 1, 0, 8'h00));
      vecs.push_back(rd(1, 8'h20, 0, 0, 0, 1, 1, 8'h00));
      vecs.push_back(rd(1, 8'h30, 0, 0, 0, 1, 2, 8'h00));
      vecs.push_back(rd(1, 8'h40, 0, 0, 0, 1, 3, 8'h00));
      vecs.push_back(rd(1, 8'h50, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(rd(1, 8'h50, 1, 2, 1, 0, 0, 8'h30));
      vecs.push_back(rd(1, 8'h50, 0, 0, 0, 1, 2, 8'h00));
      vecs.push_back(rd(0, 8'h00, 1, 1, 0, 0, 0, 8'h20));
      vecs.push_back(rd(0, 8'h00, 1, 3, 1, 0, 0, 8'h40));
      vecs.push_back(rd(0, 8'h00, 1, 1, 1, 0, 0, 8'h20));
      vecs.push_back(rd(0, 8'h00, 1, 0, 1, 0, 0, 8'h10));
      vecs.push_back(rd(0, 8'h00, 1, 2, 1, 0, 0, 8'h50));
      vecs.push_back(rd(1, 8'h10, 0, 0, 0, 1, 0, 8'h00));
      vecs.push_back(rd(1, 8'h20, 0, 0, 0, 1, 1, 8'h00));
      vecs.push_back(rd(0, 8'h00, 1, 1, 1, 0, 0, 8'h20));
      vecs.push_back(rd(0, 8'h00, 1, 0, 1, 0, 0, 8'h10));
      for (int i = 0; i < MAXT; i++) vecs.push_back(rd(1, 8'h77, 0, 0, 0, 1, 0, 8'h00));
      vecs.push_back(rd(1, 8'h77, 0, 0, 0, 0, 0, 8'h00));
      vecs.push_back(rd(1, 8'h77, 1, 0, 1, 0, 0, 8'h77));
      vecs.push_back(rd(1, 8'h77, 0, 0, 0, 1, 0, 8'h00));
      vecs.push_back(wr(1, 8'h33, 0, 0, 1, 0, 8'h00, 0));
      vecs.push_back(wr(1, 8'h33, 1, 0, 1, 0, 8'h33, 0));
      vecs.push_back(wr(0, 8'h00, 1, 0, 0, 0, 8'h33, 0));
      vecs.push_back(wr(1, 8'h44, 0, 0, 1, 0, 8'h00, 0));
      vecs.push_back(wr(0, 8'h00, 1, 2, 0, 0, 8'h00, 0));
      vecs.push_back(wr(0, 8'h00, 0, 0, 0, 0, 8'h00, 1));
      vecs.push_back(wr(0, 8'h00, 1, 0, 0, 0, 8'h44, 1));

      do_reset();
      foreach (vecs[k]) begin
         @(negedge aclk);
         drive_idle();
         s_axi_arvalid = vecs[k].arv; s_axi_arid = vecs[k].arid; m_axi_arready = vecs[k].arv;
         m_axi_rvalid = vecs[k].rv; m_axi_rid = vecs[k].rid; m_axi_rlast = vecs[k].rlast;
         s_axi_awvalid = vecs[k].awv; s_axi_awid = vecs[k].awid; m_axi_awready = vecs[k].awv;
         m_axi_bvalid = vecs[k].bv; m_axi_bid = vecs[k].bid;
         #4;
         chk($sformatf("vec%0d m_arvalid", k), 64'(m_axi_arvalid), 64'(vecs[k].e_ar));
         chk($sformatf("vec%0d s_arready", k), 64'(s_axi_arready), 64'(vecs[k].e_ar));
         if (vecs[k].e_ar) chk($sformatf("vec%0d m_arid", k), 64'(m_axi_arid), 64'(vecs[k].e_arid));
         if (vecs[k].rv) chk($sformatf("vec%0d s_rid", k), 64'(s_axi_rid), 64'(vecs[k].e_rid));
         chk($sformatf("vec%0d m_awvalid", k), 64'(m_axi_awvalid), 64'(vecs[k].e_aw));
         chk($sformatf("vec%0d s_awready", k), 64'(s_axi_awready), 64'(vecs[k].e_aw));
         if (vecs[k].e_aw) chk($sformatf("vec%0d m_awid", k), 64'(m_axi_awid), 64'(vecs[k].e_awid));
         if (vecs[k].bv) chk($sformatf("vec%0d s_bid", k), 64'(s_axi_bid), 64'(vecs[k].e_bid));
         chk($sformatf("vec%0d id_err", k), 64'(id_err), 64'(vecs[k].e_err));
      end

      // Reset in the middle of traffic: read entry 0 is at max depth, id_err is set.
      @(negedge aclk);
      drive_idle();
      s_axi_arvalid = 1; s_axi_arid = 8'h77; m_axi_arready = 1;
      s_axi_awvalid = 1; s_axi_awid = 8'h66; m_axi_awready = 1;
      #4;
      chk("pre_rst ar stall", 64'(m_axi_arvalid), 64'(0));
      chk("pre_rst id_err", 64'(id_err), 64'(1));
      chk("pre_rst m_awid", 64'(m_axi_awid), 64'(0));
      @(negedge aclk);
      s_axi_awvalid = 0; m_axi_awready = 0;
      m_axi_bvalid = 1; m_axi_bid = 0;
      #1;
      chk("pre_rst s_bid", 64'(s_axi_bid), 64'(8'h66));
      #1 aresetn = 0;
      #1;
      chk("mid_rst id_err", 64'(id_err), 64'(0));
      chk("mid_rst m_arvalid", 64'(m_axi_arvalid), 64'(1));
      chk("mid_rst m_arid", 64'(m_axi_arid), 64'(0));
      chk("mid_rst s_bid", 64'(s_axi_bid), 64'(0));
      drive_idle();
      @(negedge aclk);
      aresetn = 1;
      s_axi_arvalid = 1; s_axi_arid = 8'h5A; m_axi_arready = 1;
      #4;
      chk("post_rst m_arvalid", 64'(m_axi_arvalid), 64'(1));
      chk("post_rst m_arid", 64'(m_axi_arid), 64'(0));
      @(negedge aclk);
      s_axi_arvalid = 0; m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rid = 1; m_axi_rlast = 1;
      #4;
      chk("post_rst orphan s_rid", 64'(s_axi_rid), 64'(0));
      chk("post_rst id_err low", 64'(id_err), 64'(0));
      @(negedge aclk);
      m_axi_rid = 0;
      #4;
      chk("post_rst s_rid", 64'(s_axi_rid), 64'(8'h5A));
      chk("post_rst id_err set", 64'(id_err), 64'(1));

      // Random traffic against the model.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge aclk);
         s_axi_arvalid = ($urandom_range(0, 2) != 0);
         s_axi_arid = SW'($urandom_range(1, 6));
         m_axi_arready = ($urandom_range(0, 3) != 0);
         s_axi_araddr = $urandom;
         s_axi_arlen = 8'($urandom);
         s_axi_awvalid = ($urandom_range(0, 2) != 0);
         s_axi_awid = SW'($urandom_range(1, 6));
         m_axi_awready = ($urandom_range(0, 3) != 0);
         s_axi_awaddr = $urandom;
         m_axi_rvalid = $urandom_range(0, 1) == 1;
         m_axi_rid = pick_rsp(0);
         m_axi_rlast = $urandom_range(0, 1) == 1;
         m_axi_rdata = {$urandom, $urandom};
         s_axi_rready = ($urandom_range(0, 3) != 0);
         m_axi_bvalid = ($urandom_range(0, 2) == 0);
         m_axi_bid = pick_rsp(1);
         s_axi_bready = ($urandom_range(0, 3) != 0);
         s_axi_wvalid = $urandom_range(0, 1) == 1;
         s_axi_wdata = {$urandom, $urandom};
         m_axi_wready = $urandom_range(0, 1) == 1;
         #4;
         predict(0, int'(s_axi_arid), ok_r, mid_r);
         predict(1, int'(s_axi_awid), ok_w, mid_w);
         ow_r = owner(0, int'(m_axi_rid));
         ow_w = owner(1, int'(m_axi_bid));
         chk("rnd m_arvalid", 64'(m_axi_arvalid), 64'(s_axi_arvalid && ok_r));
         chk("rnd s_arready", 64'(s_axi_arready), 64'(m_axi_arready && ok_r));
         if (s_axi_arvalid && ok_r) chk("rnd m_arid", 64'(m_axi_arid), 64'(mid_r));
         chk("rnd m_awvalid", 64'(m_axi_awvalid), 64'(s_axi_awvalid && ok_w));
         chk("rnd s_awready", 64'(s_axi_awready), 64'(m_axi_awready && ok_w));
         if (s_axi_awvalid && ok_w) chk("rnd m_awid", 64'(m_axi_awid), 64'(mid_w));
         if (m_axi_rvalid) chk("rnd s_rid", 64'(s_axi_rid), 64'(ow_r < 0 ? 0 : ow_r));
         if (m_axi_bvalid) chk("rnd s_bid", 64'(s_axi_bid), 64'(ow_w < 0 ? 0 : ow_w));
         chk("rnd id_err", 64'(id_err), 64'(merr));
         chk("rnd araddr", 64'(m_axi_araddr), 64'(s_axi_araddr));
         chk("rnd arlen", 64'(m_axi_arlen), 64'(s_axi_arlen));
         chk("rnd awaddr", 64'(m_axi_awaddr), 64'(s_axi_awaddr));
         chk("rnd rdata", s_axi_rdata, m_axi_rdata);
         chk("rnd wdata", m_axi_wdata, s_axi_wdata);
         chk("rnd wready", 64'(s_axi_wready), 64'(m_axi_wready));
         chk("rnd rready", 64'(m_axi_rready), 64'(s_axi_rready));
         rsp_r = m_axi_rvalid && s_axi_rready;
         rsp_w = m_axi_bvalid && s_axi_bready;
         model_step(0, s_axi_arvalid && m_axi_arready && ok_r, int'(s_axi_arid), mid_r,
                    rsp_r, rsp_r && m_axi_rlast, int'(m_axi_rid));
         model_step(1, s_axi_awvalid && m_axi_awready && ok_w, int'(s_axi_awid), mid_w,
                    rsp_w, rsp_w, int'(m_axi_bid));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
